// File: rtl/decoder24_pkg.sv
// Shared types and helpers for the 2-to-4 decoder scan controller.
// Contents: FSM state enum, line count / select width, and the line-finder
//   functions first_line (lowest set mask bit) and next_line ({wrap, idx}).
package decoder24_pkg;

  localparam int LINE_CNT = 4;
  localparam int SEL_W    = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  // Lowest-index set bit of mask; 0 when mask is empty (callers guard that case).
  function automatic logic [SEL_W-1:0] first_line(input logic [LINE_CNT-1:0] mask);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = LINE_CNT - 1; i >= 0; i--) begin
      if (mask[i]) idx = SEL_W'(i);
    end
    return idx;
  endfunction

  // Lowest set bit strictly above cur; if none, wrap to the lowest set bit
  // and flag the wrap (end of sweep). Returns {wrap_flag, idx}.
  function automatic logic [SEL_W:0] next_line(input logic [LINE_CNT-1:0] mask,
                                               input logic [SEL_W-1:0]    cur);
    logic [SEL_W-1:0] above;
    logic             has_above;
    above     = '0;
    has_above = 1'b0;
    for (int i = LINE_CNT - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) begin
        above     = SEL_W'(i);
        has_above = 1'b1;
      end
    end
    return has_above ? {1'b0, above} : {1'b1, first_line(mask)};
  endfunction

endpackage

// File: rtl/decoder24_next_sel.sv
// Combinational next-line finder: next set mask bit above cur, with wrap flag.
// Ports: mask (line-enable mask), cur (current line), nxt (next line index),
//   wrap (1 when the search wrapped to the lowest set bit, i.e. sweep end).
module decoder24_next_sel
  import decoder24_pkg::*;
(
  input  logic [LINE_CNT-1:0] mask,
  input  logic [SEL_W-1:0]    cur,
  output logic [SEL_W-1:0]    nxt,
  output logic                wrap
);

  always_comb begin
    {wrap, nxt} = next_line(mask, cur);
  end

endmodule

// File: rtl/decoder24_scan_ctrl.sv
// Round-robin scan controller driving a 2-to-4 decoder (sel -> din, sel_en -> en).
// Ports: clk, rst_n (sync active-low), start/stop control, mask, dwell;
//   registered outputs sel, sel_en, busy, frame_done.
// Build option: SCAN_ONESHOT_EN makes each start run a single sweep then idle.
module decoder24_scan_ctrl
  import decoder24_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic [LINE_CNT-1:0] mask,
  input  logic [DWELL_W-1:0]  dwell,
  output logic [SEL_W-1:0]    sel,
  output logic                sel_en,
  output logic                busy,
  output logic                frame_done
);

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                sel_en_q, sel_en_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;
  logic [DWELL_W-1:0]  cnt_q, cnt_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic [LINE_CNT-1:0] mask_q, mask_d;

  logic [SEL_W-1:0]    step_idx;
  logic                step_wrap;

  // Successor of the current line within the mask latched for this sweep.
  decoder24_next_sel u_next_sel (
    .mask (mask_q),
    .cur  (sel_q),
    .nxt  (step_idx),
    .wrap (step_wrap)
  );

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    sel_en_d     = 1'b0;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    cnt_d        = cnt_q;
    dwell_d      = dwell_q;
    mask_d       = mask_q;

    if (stop) begin
      // Abort: sel is held so the decoder input does not glitch.
      state_d = IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && (mask != '0)) begin
            state_d = SETUP;
            busy_d  = 1'b1;
            dwell_d = dwell;
            mask_d  = mask;
            sel_d   = first_line(mask);
          end
        end
        SETUP: begin
          state_d  = ACTIVE;
          sel_en_d = 1'b1;
          cnt_d    = '0;
        end
        ACTIVE: begin
          // Compare before increment so an all-ones dwell never wraps the counter.
          if (cnt_q == dwell_q) begin
            if (!step_wrap) begin
              state_d = SETUP;
              sel_d   = step_idx;
            end else begin
              // Sweep boundary: the live mask only takes effect here.
              frame_done_d = 1'b1;
              mask_d       = mask;
`ifdef SCAN_ONESHOT_EN
              state_d = IDLE;
              busy_d  = 1'b0;
`else
              if (mask == '0) begin
                state_d = IDLE;
                busy_d  = 1'b0;
              end else begin
                state_d = SETUP;
                sel_d   = first_line(mask);
              end
`endif
            end
          end else begin
            sel_en_d = 1'b1;
            cnt_d    = cnt_q + DWELL_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      sel_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      cnt_q        <= '0;
      dwell_q      <= '0;
      mask_q       <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      sel_en_q     <= sel_en_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      cnt_q        <= cnt_d;
      dwell_q      <= dwell_d;
      mask_q       <= mask_d;
    end
  end

  assign sel        = sel_q;
  assign sel_en     = sel_en_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_decoder24_scan_ctrl.sv
// Scoreboard bench for decoder24_scan_ctrl: per-cycle expected
// {sel, sel_en, busy, frame_done} tuples are queued with the stimulus and
// popped/compared one per clock, sampled 1 time unit after the rising edge.
module tb_decoder24_scan_ctrl;

  localparam int DWELL_W = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic               stop;
  logic [3:0]         mask;
  logic [DWELL_W-1:0] dwell;
  logic [1:0]         sel;
  logic               sel_en;
  logic               busy;
  logic               frame_done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [4:0] exp_q[$];
  string      tag_q[$];

  always #5 clk = ~clk;

  decoder24_scan_ctrl #(.DWELL_W(DWELL_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .mask       (mask),
    .dwell      (dwell),
    .sel        (sel),
    .sel_en     (sel_en),
    .busy       (busy),
    .frame_done (frame_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got {sel,en,busy,fd}=%b expected %b", tag, cyc, got[4:0], exp[4:0]);
    end
  endtask

  task automatic push(input string tag, input logic [1:0] s, input logic e, input logic b, input logic f);
    exp_q.push_back({s, e, b, f});
    tag_q.push_back(tag);
  endtask

  // One scanned line: a SETUP cycle then dwell+1 ACTIVE cycles.
  task automatic push_line(input string tag, input logic [1:0] s, input int dw, input logic f);
    push(tag, s, 1'b0, 1'b1, f);
    repeat (dw + 1) push(tag, s, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic step();
    logic [4:0] e;
    string      t;
    @(posedge clk);
    #1;
    cyc++;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_empty cycle %0d", cyc);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, {27'd0, sel, sel_en, busy, frame_done}, {27'd0, e});
    end
  endtask

  task automatic drain();
    while (exp_q.size() != 0) step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mask = 4'b0000; dwell = '0;

    // Reset state
    push("reset", 2'd0, 0, 0, 0);
    push("reset", 2'd0, 0, 0, 0);
    drain();
    rst_n = 1'b1;

    // start with empty mask is ignored
    mask = 4'b0000; start = 1'b1;
    push("start_mask0", 2'd0, 0, 0, 0);
    push("start_mask0", 2'd0, 0, 0, 0);
    drain();
    // start and stop together: stop wins
    mask = 4'b0011; stop = 1'b1;
    push("start_stop", 2'd0, 0, 0, 0);
    step();
    start = 1'b0; stop = 1'b0;
    push("start_stop_after", 2'd0, 0, 0, 0);
    step();

    // Reset asserted mid-ACTIVE on line 1
    mask = 4'b0010; dwell = 8'd3; start = 1'b1;
    push("rst_mid", 2'd1, 0, 1, 0);
    push("rst_mid", 2'd1, 1, 1, 0);
    push("rst_mid", 2'd1, 1, 1, 0);
    step();
    start = 1'b0;
    drain();
    rst_n = 1'b0;
    push("rst_mid_zero", 2'd0, 0, 0, 0);
    push("rst_mid_zero", 2'd0, 0, 0, 0);
    drain();
    rst_n = 1'b1;

`ifdef SCAN_ONESHOT_EN
    // One sweep over lines 1,2 then idle
    mask = 4'b0110; dwell = 8'd1; start = 1'b1;
    push_line("oneshot", 2'd1, 1, 0);
    push_line("oneshot", 2'd2, 1, 0);
    push("oneshot_end", 2'd2, 0, 0, 1);
    repeat (3) push("oneshot_idle", 2'd2, 0, 0, 0);
    step();
    start = 1'b0;
    drain();

    // All-ones dwell, single line, single sweep
    mask = 4'b0100; dwell = 8'hFF; start = 1'b1;
    push_line("dwell_max", 2'd2, 255, 0);
    push("dwell_max_end", 2'd2, 0, 0, 1);
    push("dwell_max_idle", 2'd2, 0, 0, 0);
    step();
    start = 1'b0;
    drain();
`else
    // Full sweep, start held high (ignored while busy); frame_done at cycles 17 and 33
    mask = 4'b1111; dwell = 8'd2; start = 1'b1;
    for (int s = 0; s < 4; s++) push_line("sweep1", 2'(s), 2, 1'b0);
    for (int s = 0; s < 4; s++) push_line("sweep2", 2'(s), 2, s == 0);
    push("sweep3_setup", 2'd0, 0, 1, 1);
    drain();
    start = 1'b0; stop = 1'b1;
    push("stop_setup", 2'd0, 0, 0, 0);
    step();
    stop = 1'b0;

    // Skip and wrap over lines 1,3 with minimum dwell; stop in last ACTIVE of a sweep
    mask = 4'b1010; dwell = 8'd0; start = 1'b1;
    push_line("skip", 2'd1, 0, 0);
    push_line("skip", 2'd3, 0, 0);
    push_line("skip", 2'd1, 0, 1);
    push_line("skip", 2'd3, 0, 0);
    push_line("skip", 2'd1, 0, 1);
    push_line("skip", 2'd3, 0, 0);
    step();
    start = 1'b0;
    drain();
    stop = 1'b1;
    push("stop_active", 2'd3, 0, 0, 0);
    step();
    stop = 1'b0;

    // Mask change mid-sweep takes effect at the wrap
    mask = 4'b1111; dwell = 8'd1; start = 1'b1;
    push_line("mchg", 2'd0, 1, 0);
    push("mchg", 2'd1, 0, 1, 0);
    step();
    start = 1'b0;
    drain();
    mask = 4'b0001;
    push("mchg", 2'd1, 1, 1, 0);
    push("mchg", 2'd1, 1, 1, 0);
    push_line("mchg", 2'd2, 1, 0);
    push_line("mchg", 2'd3, 1, 0);
    push_line("mchg_l0", 2'd0, 1, 1);
    push("mchg_l0", 2'd0, 0, 1, 1);
    drain();
    mask = 4'b1111;
    push("mchg_l0", 2'd0, 1, 1, 0);
    push("mchg_l0", 2'd0, 1, 1, 0);
    push_line("mchg_back", 2'd0, 1, 1);
    push("mchg_back", 2'd1, 0, 1, 0);
    drain();
    mask = 4'b0000;
    push("mzero", 2'd1, 1, 1, 0);
    push("mzero", 2'd1, 1, 1, 0);
    push_line("mzero", 2'd2, 1, 0);
    push_line("mzero", 2'd3, 1, 0);
    push("mzero_idle", 2'd3, 0, 0, 1);
    push("mzero_idle", 2'd3, 0, 0, 0);
    drain();

    // All-ones dwell on a single line: repeats every sweep, no counter wrap
    mask = 4'b0100; dwell = 8'hFF; start = 1'b1;
    push_line("dwell_max", 2'd2, 255, 0);
    push_line("dwell_max", 2'd2, 255, 1);
    step();
    start = 1'b0;
    drain();
    stop = 1'b1;
    push("dwell_max_stop", 2'd2, 0, 0, 0);
    step();
    stop = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
